// File: rtl/apple2_disk_pkg.sv
// Shared constants, widths and loader state encoding for the Disk II track loader.
package apple2_disk_pkg;
  localparam int TRACK_BYTES = 6656;
  localparam int NUM_TRACKS  = 35;
  localparam int IMG_ADDR_W  = 18;
  localparam int TRK_ADDR_W  = 14;
  localparam int OFS_W       = 13;

  typedef enum logic [1:0] {IDLE, SETTLE, FETCH, FILL} loader_state_t;

  // 6656 = 4096 + 2048 + 512, so the track base needs no multiplier
  function automatic logic [IMG_ADDR_W-1:0] track_base(input logic [5:0] t);
    logic [IMG_ADDR_W-1:0] tw;
    tw = IMG_ADDR_W'(t);
    return (tw << 12) + (tw << 11) + (tw << 9);
  endfunction
endpackage

// File: rtl/apple2_disk_track_loader.sv
// Copies the nibble track under the head from the image store into the controller's
// track RAM, after the head position has been stable for SETTLE_CYCLES.
module apple2_disk_track_loader
  import apple2_disk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                  clk_14m,
  input  logic                  reset,
  input  logic [5:0]            track,
  input  logic                  image_present,
  output logic [IMG_ADDR_W-1:0] img_addr,
  output logic                  img_rd_req,
  input  logic                  img_rd_valid,
  input  logic [7:0]            img_rd_data,
  output logic [TRK_ADDR_W-1:0] ram_write_addr,
  output logic [7:0]            ram_di,
  output logic                  ram_we,
  output logic                  busy,
  output logic                  track_valid,
  output logic [5:0]            loaded_track
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(TRACK_BYTES - 1);
  localparam logic [5:0]       TRK_LIM  = 6'(NUM_TRACKS);

  loader_state_t         state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [5:0]            target, target_nxt;
  logic [IMG_ADDR_W-1:0] base, base_nxt;
  logic [OFS_W-1:0]      offset, offset_nxt;
  logic                  abort, abort_nxt;
  logic [IMG_ADDR_W-1:0] img_addr_nxt;
  logic                  img_rd_req_nxt;
  logic [TRK_ADDR_W-1:0] ram_write_addr_nxt;
  logic [7:0]            ram_di_nxt;
  logic                  ram_we_nxt;
  logic                  track_valid_nxt;
  logic [5:0]            loaded_track_nxt;
  logic                  leave, do_exit, do_done;

  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    target_nxt         = target;
    base_nxt           = base;
    offset_nxt         = offset;
    abort_nxt          = abort;
    img_addr_nxt       = img_addr;
    img_rd_req_nxt     = img_rd_req;
    ram_write_addr_nxt = ram_write_addr;
    ram_di_nxt         = ram_di;
    ram_we_nxt         = 1'b0;
    track_valid_nxt    = track_valid;
    loaded_track_nxt   = loaded_track;
    leave              = !image_present || (track != target);
    do_exit            = 1'b0;
    do_done            = 1'b0;

    case (state)
      IDLE: begin
        if (!image_present) track_valid_nxt = 1'b0;
        else if (!track_valid || track != loaded_track) begin
          state_nxt       = SETTLE;
          target_nxt      = track;
          cnt_nxt         = CNT_LOAD;
          track_valid_nxt = 1'b0;
        end
      end
      SETTLE: begin
        if (!image_present) do_exit = 1'b1;
        else if (track != target) begin
          target_nxt = track;
          cnt_nxt    = CNT_LOAD;
        end else if (cnt == '0) begin
          base_nxt   = track_base(target);
          offset_nxt = '0;
          if (target < TRK_LIM) begin
            state_nxt      = FETCH;
            img_rd_req_nxt = 1'b1;
            img_addr_nxt   = track_base(target);
          end else begin
            state_nxt = FILL;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      FETCH: begin
        if (!img_rd_req) begin
          if (leave) do_exit = 1'b1;
          else begin
            img_rd_req_nxt = 1'b1;
            img_addr_nxt   = base + IMG_ADDR_W'(offset);
          end
        end else if (!img_rd_valid) begin
          // a request in flight must complete; remember to throw its byte away
          abort_nxt = abort | leave;
        end else begin
          img_rd_req_nxt = 1'b0;
          abort_nxt      = 1'b0;
          if (abort || leave) do_exit = 1'b1;
          else begin
            ram_we_nxt         = 1'b1;
            ram_di_nxt         = img_rd_data;
            ram_write_addr_nxt = TRK_ADDR_W'(offset);
            if (offset == LAST_OFS) do_done = 1'b1;
            else offset_nxt = offset + OFS_W'(1);
          end
        end
      end
      FILL: begin
        if (leave) do_exit = 1'b1;
        else begin
          ram_we_nxt         = 1'b1;
          ram_di_nxt         = 8'h00;
          ram_write_addr_nxt = TRK_ADDR_W'(offset);
          if (offset == LAST_OFS) do_done = 1'b1;
          else offset_nxt = offset + OFS_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (do_exit) begin
      track_valid_nxt = 1'b0;
      if (!image_present) state_nxt = IDLE;
      else begin
        state_nxt  = SETTLE;
        target_nxt = track;
        cnt_nxt    = CNT_LOAD;
      end
    end
    if (do_done) begin
      state_nxt        = IDLE;
      loaded_track_nxt = target;
      track_valid_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk_14m) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      target         <= '0;
      base           <= '0;
      offset         <= '0;
      abort          <= 1'b0;
      img_addr       <= '0;
      img_rd_req     <= 1'b0;
      ram_write_addr <= '0;
      ram_di         <= '0;
      ram_we         <= 1'b0;
      track_valid    <= 1'b0;
      loaded_track   <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      target         <= target_nxt;
      base           <= base_nxt;
      offset         <= offset_nxt;
      abort          <= abort_nxt;
      img_addr       <= img_addr_nxt;
      img_rd_req     <= img_rd_req_nxt;
      ram_write_addr <= ram_write_addr_nxt;
      ram_di         <= ram_di_nxt;
      ram_we         <= ram_we_nxt;
      track_valid    <= track_valid_nxt;
      loaded_track   <= loaded_track_nxt;
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: doc/apple2_disk_track_loader.md
Name: apple2_disk_track_loader

Overview:
- Upstream feeder for the Disk II controller's track RAM.
- Watches the head track number and pulls the matching 6656-byte nibble track from the disk image store through a req/valid read port.
- Streams each byte into the controller's track RAM write port (ram_write_addr/ram_di/ram_we).
- Debounces head stepping so seeks do not trigger a reload for every intermediate track.

Parameters:
- TRACK_BYTES, 6656, nibble bytes per track; also the last RAM address + 1.
- NUM_TRACKS, 35, tracks present in the image; higher track numbers are unformatted.
- SETTLE_CYCLES, 1024, clk_14m cycles the track must stay stable before a load starts.

Ports:
- clk_14m  in  1  system clock.
- reset  in  1  synchronous, active-high.
- track  in  6  current head track from the controller.
- image_present  in  1  disk image mounted; low = no disk.
- img_addr  out  18  image byte address = track*TRACK_BYTES + offset.
- img_rd_req  out  1  read request; held until accepted.
- img_rd_valid  in  1  read data valid; honoured only while img_rd_req=1.
- img_rd_data  in  8  read data, sampled when img_rd_valid=1.
- ram_write_addr  out  14  track RAM write address.
- ram_di  out  8  track RAM write data.
- ram_we  out  1  track RAM write strobe, one cycle per byte.
- busy  out  1  high in SETTLE/FETCH/FILL.
- track_valid  out  1  RAM holds loaded_track completely.
- loaded_track  out  6  track currently held in RAM.

Behaviour:
- Reset: all outputs 0, state IDLE, settle counter 0, offset 0.
- States:
  - IDLE: go to SETTLE when image_present=1 and (track_valid=0 or track!=loaded_track). If image_present=0, stay in IDLE and force track_valid=0.
  - SETTLE: latch target=track and clear track_valid, both on entry. Count SETTLE_CYCLES-1 down to 0. If track!=target, re-latch target and reload the count. At count 0, compute base = (target<<12)+(target<<11)+(target<<9) into an 18-bit register, set offset=0, and go to FETCH (target<NUM_TRACKS) or FILL (otherwise).
  - FETCH: img_rd_req=1 and img_addr=base+offset are stable until img_rd_valid. On the valid cycle, register ram_di=img_rd_data and ram_write_addr=offset, and pulse ram_we the next cycle. Then offset+1; img_rd_req drops for exactly one cycle between bytes.
  - FILL: write 8'h00 to offsets 0..TRACK_BYTES-1, one byte per cycle, with no image reads.
  - Completion: after offset TRACK_BYTES-1 is written, set loaded_track=target and track_valid=1 together with the final ram_we cycle, then return to IDLE.
- Timing: write latency is 1 cycle from accepted img_rd_valid to ram_we. FILL takes exactly TRACK_BYTES write cycles.
- Track change during FETCH/FILL: finish any outstanding request (img_rd_req never drops before valid) but discard its data (no ram_we). Return to SETTLE with a new target. track_valid stays 0.
- image_present falling in any state: same rule for an outstanding request, then IDLE with track_valid=0.
- Address width: offset is 13 bits, wrapping is impossible. Max img_addr = 34*6656+6655 = 232959 < 2^18.
- Reset mid-load: immediate return to IDLE, even with a request outstanding. The image port must tolerate a dropped request.

Decomposition:
- Shared package apple2_disk_pkg holds:
  - TRACK_BYTES, NUM_TRACKS;
  - the IMG_ADDR_W=18 and TRK_ADDR_W=14 widths;
  - the loader state enum (IDLE, SETTLE, FETCH, FILL).
- No sub-module: a single FSM plus counters.

Test Plan:
- Reset, image_present=1, track=17, SETTLE_CYCLES=16:
  - exactly 6656 ram_we pulses at addresses 0..6655;
  - img_addr runs 113152..119807;
  - ram_di echoes the image model;
  - then track_valid=1 and loaded_track=17.
- Step track 17→18→19, 4 cycles apart:
  - no img_rd_req until 16 stable cycles on 19;
  - the load uses base 126464.
- Change track at byte 3000 with a request outstanding (valid delayed 5 cycles):
  - img_rd_req stays high until valid, with no ram_we for that byte;
  - a new SETTLE follows and track_valid stays 0.
- track=40:
  - 6656 consecutive ram_we cycles with ram_di=0 and no img_rd_req;
  - then loaded_track=40, track_valid=1.
- Drop image_present mid-load:
  - track_valid=0 and busy=0 after the outstanding read completes;
  - when it rises again, the same track reloads fully.
- Randomised img_rd_valid latency 0–7 cycles on track 0:
  - RAM contents match image bytes 0..6655;
  - ram_we is never asserted without a preceding accepted valid.
